// File: rtl/hht_val_buffer_if.sv
// Bus bundle for hht_val_buffer: gather-control inputs, CPU load port and FIFO status.
// The HHT/CPU side drives through master; the buffer attaches as slave.
interface hht_val_buffer_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          start;
   logic [31:0]   csize;
   logic          wn;
   logic [31:0]   dataIn;
   logic          cpu_req;
   logic [31:0]   cpu_addr;
   logic [31:0]   dataOut;
   logic          valid_out;
   logic          stall;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          done;
   logic          ovf;

   modport master (
      output start, csize, wn, dataIn, cpu_req, cpu_addr,
      input  dataOut, valid_out, stall, full, empty, count, done, ovf
   );

   modport slave (
      input  start, csize, wn, dataIn, cpu_req, cpu_addr,
      output dataOut, valid_out, stall, full, empty, count, done, ovf
   );
endinterface

// File: rtl/hht_val_buffer.sv
// FIFO of gathered vector values popped by CPU loads from CPU_PORT; a gather of csize elements.
// Optional macro HHT_BUF_FWD_EN: a hit meeting an empty FIFO with a same-cycle push forwards dataIn.
module hht_val_buffer #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] CPU_PORT = 32'd126
) (
   input  logic            Clk,
   input  logic            Rst,
   hht_val_buffer_if.slave bus,
   output logic [1:0]      dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   remaining_q, remaining_d;
   logic [31:0]   data_out_q, data_out_d;
   logic          valid_out_q, valid_out_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   mem_q [DEPTH];

   logic hit, active, fwd, pop, push, deliver;

   assign hit    = bus.cpu_req && (bus.cpu_addr == CPU_PORT);
   assign active = (state_q == S_ACTIVE);

   // start owns the cycle, so no transfer may ride along with it.
`ifdef HHT_BUF_FWD_EN
   assign fwd = active && !bus.start && hit && bus.wn && empty_q;
`else
   assign fwd = 1'b0;
`endif
   assign pop     = active && !bus.start && hit && !empty_q;
   assign push    = active && !bus.start && bus.wn && !fwd && (!full_q || pop);
   assign deliver = pop || fwd;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      ovf_d       = ovf_q;

      if (bus.start) begin
         state_d     = (bus.csize == 32'd0) ? S_DONE : S_ACTIVE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         remaining_d = bus.csize;
         ovf_d       = 1'b0;
      end else if (active) begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
         end
         if (fwd) begin
            data_out_d = bus.dataIn;
         end
         if (deliver) begin
            valid_out_d = 1'b1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
               state_d = S_DONE;
            end
         end
         // A strobe that neither lands in the FIFO nor forwards is a lost value.
         if (bus.wn && !push && !fwd) begin
            ovf_d = 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage needs no reset: count and pointers decide what is readable.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.dataIn;
      end
   end

   assign bus.dataOut   = data_out_q;
   assign bus.valid_out = valid_out_q;
   assign bus.stall     = active && hit && empty_q && !fwd;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;
   assign bus.done      = (state_q == S_DONE);
   assign bus.ovf       = ovf_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_hht_val_buffer.sv
// Bench for hht_val_buffer: directed scenarios then random traffic, every cycle compared
// against a queue-based model of the gather buffer.
module tb_hht_val_buffer;
   localparam int          DEPTH = 8;
   localparam logic [31:0] PORT  = 32'd126;
`ifdef HHT_BUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   hht_val_buffer_if #(.DEPTH(DEPTH)) bus ();

   hht_val_buffer #(.DEPTH(DEPTH), .CPU_PORT(PORT)) dut (
      .Clk       (clk),
      .Rst       (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Reference model: mode 0 = idle, 1 = gathering, 2 = finished.
   logic [31:0] exp_q[$];
   int          m_mode = 0;
   logic [31:0] m_rem  = 0;
   logic [31:0] m_dout = 0;
   bit          m_vout = 0;
   bit          m_ovf  = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit hit, fwd;
      hit = bus.cpu_req && (bus.cpu_addr == PORT);
      fwd = FWD && (m_mode == 1) && !bus.start && hit && bus.wn && (exp_q.size() == 0);
      #1;
      check("stall", bus.stall, 32'((m_mode == 1) && hit && (exp_q.size() == 0) && !fwd));

      if (!rst_n) begin
         exp_q.delete();
         m_mode = 0; m_rem = 0; m_dout = 0; m_vout = 0; m_ovf = 0;
      end else if (bus.start) begin
         exp_q.delete();
         m_ovf  = 0;
         m_rem  = bus.csize;
         m_mode = (bus.csize == 0) ? 2 : 1;
         m_vout = 0;
      end else if (m_mode == 1) begin
         m_vout = 0;
         if (fwd) begin
            m_dout = bus.dataIn;
            m_vout = 1;
         end else begin
            if (hit && exp_q.size() > 0) begin
               m_dout = exp_q.pop_front();
               m_vout = 1;
            end
            if (bus.wn) begin
               if (exp_q.size() < DEPTH) exp_q.push_back(bus.dataIn);
               else m_ovf = 1;
            end
         end
         if (m_vout) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mode = 2;
         end
      end else begin
         m_vout = 0;
      end

      @(posedge clk);
      #1;
      check("dataOut",   bus.dataOut,   m_dout);
      check("valid_out", bus.valid_out, 32'(m_vout));
      check("count",     bus.count,     exp_q.size());
      check("full",      bus.full,      32'(exp_q.size() == DEPTH));
      check("empty",     bus.empty,     32'(exp_q.size() == 0));
      check("done",      bus.done,      32'(m_mode == 2));
      check("ovf",       bus.ovf,       32'(m_ovf));
   endtask

   task automatic drive(input bit st, input logic [31:0] cs, input bit w, input logic [31:0] d,
                        input bit req, input logic [31:0] addr);
      bus.start    = st;
      bus.csize    = cs;
      bus.wn       = w;
      bus.dataIn   = d;
      bus.cpu_req  = req;
      bus.cpu_addr = addr;
      cycle();
   endtask

   task automatic idle();             drive(0, 0, 0, 0, 0, 0);    endtask
   task automatic do_start(input logic [31:0] n); drive(1, n, 0, 0, 0, 0); endtask
   task automatic do_push(input logic [31:0] v);  drive(0, 0, 1, v, 0, 0); endtask
   task automatic do_hit();           drive(0, 0, 0, 0, 1, PORT); endtask

   initial begin
      logic [31:0] vals [3];
      bit st, w, req;
      logic [31:0] addr;
      vals = '{32'd74, 32'd10, 32'd70};

      bus.start = 0; bus.csize = 0; bus.wn = 0; bus.dataIn = 0; bus.cpu_req = 0; bus.cpu_addr = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle();
      idle();
      rst_n = 1'b1;
      idle();

      // Basic three-element gather.
      do_start(3);
      for (int i = 0; i < 3; i++) do_push(vals[i]);
      for (int i = 0; i < 3; i++) begin
         do_hit();
         check("r030_data", bus.dataOut, vals[i]);
         check("r030_vld", bus.valid_out, 1);
      end
      check("r030_done", bus.done, 1);
      idle();
      check("r030_vld_drop", bus.valid_out, 0);

      // Overfill then drain in order.
      do_start(100);
      for (int i = 0; i < 9; i++) do_push(32'(i + 1));
      check("r031_count", bus.count, 8);
      check("r031_full", bus.full, 1);
      check("r031_ovf", bus.ovf, 1);
      for (int i = 0; i < 8; i++) begin
         do_hit();
         check("r031_data", bus.dataOut, 32'(i + 1));
      end
      check("r031_empty", bus.empty, 1);

      // Hit against an empty FIFO, then hit with a simultaneous push.
      do_start(50);
      bus.cpu_req = 1; bus.cpu_addr = PORT;
      #1;
      check("r032_stall", bus.stall, 1);
      cycle();
      check("r032_vld", bus.valid_out, 0);
      check("r032_count", bus.count, 0);
      drive(0, 0, 1, FWD ? 32'd61 : 32'd85, 1, PORT);
      check("r032_count2", bus.count, FWD ? 32'd0 : 32'd1);
      check("r032_vld2", bus.valid_out, 32'(FWD));
      idle();

      // Full FIFO with simultaneous push/pop across pointer wrap.
      do_start(1000);
      for (int i = 0; i < 8; i++) do_push(32'(200 + i));
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 1, 32'(300 + i), 1, PORT);
         check("r034_data", bus.dataOut, (i < 8) ? 32'(200 + i) : 32'(300 + i - 8));
      end
      check("r034_count", bus.count, 8);
      check("r034_ovf", bus.ovf, 0);

      // Reset mid-gather, then a zero-length gather.
      do_start(100);
      for (int i = 0; i < 5; i++) do_push(32'(40 + i));
      check("r035_count5", bus.count, 5);
      rst_n = 1'b0;
      idle();
      check("r035_rst_count", bus.count, 0);
      check("r035_rst_empty", bus.empty, 1);
      check("r035_rst_dout", bus.dataOut, 0);
      rst_n = 1'b1;
      do_hit();
      check("r035_no_vld", bus.valid_out, 0);
      do_start(0);
      check("r035_done", bus.done, 1);
      do_push(7);
      check("r035_ignored", bus.ovf, 0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         st    = ((m_mode != 1) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 49) == 0);
         w     = ($urandom_range(0, 9) < 6);
         req   = ($urandom_range(0, 1) == 1);
         addr  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(120, 130)) : PORT;
         drive(st, 32'($urandom_range(0, 14)), w, $urandom, req, addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/hht_val_buffer.md
HHT_VAL_BUFFER -- requirements
Module: hht_val_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 Parameter CPU_PORT, default 32'd126, CPU load address that pops the buffer.
REQ-003 Clk  input  1  system clock, all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse arming a new gather of csize elements.
REQ-006 csize  input  32  element count for the gather, sampled on start.
REQ-007 wn  input  1  push strobe from the HHT control stage (gathered vector value).
REQ-008 dataIn  input  32  gathered value, valid with wn.
REQ-009 cpu_req  input  1  CPU load strobe.
REQ-010 cpu_addr  input  32  CPU load address; hit = cpu_req && cpu_addr==CPU_PORT.
REQ-011 dataOut  output  32  popped value, registered.
REQ-012 valid_out  output  1  dataOut valid, one-cycle pulse.
REQ-013 stall  output  1  combinational: hit and no data available this cycle.
REQ-014 full, empty  output  1 each  FIFO status, registered.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 done  output  1  all csize elements delivered to CPU.
REQ-017 ovf  output  1  sticky: push attempted while full and not popping.

Function
REQ-018 FSM states IDLE, ACTIVE, DONE; start in any state clears pointers, count, ovf, loads remaining=csize, enters ACTIVE (csize==0 -> DONE instead).
REQ-019 Push accepted only in ACTIVE when wn && (!full || pop); rejected push sets ovf, data dropped.
REQ-020 Pop occurs in ACTIVE when hit && !empty; dataOut=head entry and valid_out=1 on the following cycle.
REQ-021 Simultaneous accepted push and pop: count unchanged, both pointers advance, wrap modulo DEPTH.
REQ-022 Each pop decrements remaining; pop making remaining 0 moves FSM to DONE; done=1 in DONE only.
REQ-023 In IDLE and DONE: wn ignored (no ovf), hit never pops, stall=0, valid_out=0.
REQ-024 stall=1 in ACTIVE when hit and empty (see REQ-029 for fall-through exception).
REQ-025 full = count==DEPTH, empty = count==0; dataOut holds last value when no pop.
REQ-026 Pop on a start cycle is discarded; start takes priority over push/pop.

Reset
REQ-027 Rst low at a rising edge: state IDLE, pointers/count/remaining 0, dataOut 0, valid_out 0, done 0, ovf 0, empty 1, full 0.
REQ-028 Reset mid-gather discards buffered data; no valid_out after Rst deasserts until new start and push.

Configuration
REQ-029 Macro HHT_BUF_FWD_EN defined: in ACTIVE with empty FIFO, hit && wn in same cycle -> dataIn forwarded to dataOut with valid_out next cycle, FIFO untouched, stall=0, remaining decrements; macro undefined: that case stalls and dataIn is pushed normally.

Verification
REQ-030 Reset, start csize=3, push 74,10,70, hit x3 -> dataOut 74,10,70 each 1 cycle after hit, done=1 after third pop.
REQ-031 DEPTH=8, push 9 values no pops -> full=1 after 8, ovf=1, count=8; 8 pops return first 8 values in order.
REQ-032 Hit with empty FIFO in ACTIVE -> stall=1, valid_out=0, count 0; without macro, hit+wn(85) same cycle -> stall=1, count=1.
REQ-033 With HHT_BUF_FWD_EN: empty, hit+wn(61) same cycle -> stall=0, dataOut=61 valid_out=1 next cycle, count=0.
REQ-034 Full FIFO, push+pop same cycle 20 times across wrap -> count stays 8, ovf=0, order preserved.
REQ-035 Rst low with count=5 mid-gather -> all outputs at reset values next cycle; start csize=0 -> done=1 next cycle.
